// File: rtl/serial_add_arbiter.sv
// Two-client round-robin sequencer for a shared bit-serial adder: grants, loads, times and returns results.
// Define SERIAL_ADD_ARB_OVF_EN to add the res_ovf signed-overflow result output.
module serial_add_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
`ifdef SERIAL_ADD_ARB_OVF_EN
  output logic             res_ovf,
`endif
  output logic             busy,
  output logic             adder_load,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(ADD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_CYCLES);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cur_id_q, cur_id_d;
  logic             last_id_q, last_id_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_id_q, res_id_d;
  logic             busy_q, busy_d;
  logic             adder_load_q, adder_load_d;
  logic [WIDTH-1:0] adder_a_q, adder_a_d, adder_b_q, adder_b_d;
  logic             adder_cin_q, adder_cin_d;
  logic             win_s;
`ifdef SERIAL_ADD_ARB_OVF_EN
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             res_ovf_q, res_ovf_d;
`endif

  // On a tie the client that did not win last time is served.
  assign win_s = (req0 & req1) ? ~last_id_q : req1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_id_d     = cur_id_q;
    last_id_d    = last_id_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_id_d     = res_id_q;
    adder_load_d = 1'b0;
    adder_a_d    = adder_a_q;
    adder_b_d    = adder_b_q;
    adder_cin_d  = adder_cin_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    res_ovf_d    = res_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          adder_a_d    = win_s ? a1 : a0;
          adder_b_d    = win_s ? b1 : b0;
          adder_cin_d  = win_s ? cin1 : cin0;
          adder_load_d = 1'b1;
          gnt0_d       = ~win_s;
          gnt1_d       = win_s;
          cur_id_d     = win_s;
          last_id_d    = win_s;
`ifdef SERIAL_ADD_ARB_OVF_EN
          a_msb_d      = win_s ? a1[WIDTH-1] : a0[WIDTH-1];
          b_msb_d      = win_s ? b1[WIDTH-1] : b0[WIDTH-1];
`endif
          state_d      = LOAD;
        end else begin
          state_d      = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = {CW{1'b0}};
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          res_sum_d  = adder_sum;
          res_cout_d = adder_cout;
          res_id_d   = cur_id_q;
          done0_d    = ~cur_id_q;
          done1_d    = cur_id_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
          res_ovf_d  = (a_msb_q == b_msb_q) && (adder_sum[WIDTH-1] != a_msb_q);
`endif
          state_d    = DONE;
        end else begin
          cnt_d      = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CW{1'b0}};
      cur_id_q     <= 1'b0;
      last_id_q    <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res_sum_q    <= {WIDTH{1'b0}};
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      adder_load_q <= 1'b0;
      adder_a_q    <= {WIDTH{1'b0}};
      adder_b_q    <= {WIDTH{1'b0}};
      adder_cin_q  <= 1'b0;
`ifdef SERIAL_ADD_ARB_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      res_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_id_q     <= cur_id_d;
      last_id_q    <= last_id_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_id_q     <= res_id_d;
      busy_q       <= busy_d;
      adder_load_q <= adder_load_d;
      adder_a_q    <= adder_a_d;
      adder_b_q    <= adder_b_d;
      adder_cin_q  <= adder_cin_d;
`ifdef SERIAL_ADD_ARB_OVF_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      res_ovf_q    <= res_ovf_d;
`endif
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign res_sum    = res_sum_q;
  assign res_cout   = res_cout_q;
  assign res_id     = res_id_q;
  assign busy       = busy_q;
  assign adder_load = adder_load_q;
  assign adder_a    = adder_a_q;
  assign adder_b    = adder_b_q;
  assign adder_cin  = adder_cin_q;
`ifdef SERIAL_ADD_ARB_OVF_EN
  assign res_ovf    = res_ovf_q;
`endif

endmodule
